// File: rtl/hazard_forward_unit.sv
// Pipeline hazard control for the 16-bit core. It drives the EX operand forwarding selects,
// load-use stalls, taken-branch flushes, a freeze while data memory is busy, and perf counters.
module hazard_forward_unit #(
   parameter int unsigned ADDR_W       = 3,
   parameter int unsigned WAIT_TIMEOUT = 64,
   parameter int unsigned CNT_W        = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] id_rs,
   input  logic [ADDR_W-1:0] id_rt,
   input  logic              id_uses_rs,
   input  logic              id_uses_rt,
   input  logic [ADDR_W-1:0] ex_write_reg,
   input  logic              ex_reg_write,
   input  logic              ex_mem_read,
   input  logic              ex_branch_taken,
   input  logic              mem_req,
   input  logic              mem_ready,
   output logic [1:0]        forward_a,
   output logic [1:0]        forward_b,
   output logic              stall_if_id,
   output logic              bubble_ex,
   output logic              flush_if_id,
   output logic              freeze,
   output logic              mem_timeout,
   output logic [CNT_W-1:0]  stall_count,
   output logic [CNT_W-1:0]  flush_count
);

   localparam int unsigned WCNT_W = $clog2(WAIT_TIMEOUT + 1);
   localparam logic [1:0] FWD_REG = 2'b00;
   localparam logic [1:0] FWD_MEM = 2'b01;
   localparam logic [1:0] FWD_WB  = 2'b10;

   typedef enum logic {RUN, MEM_WAIT} state_e;

   state_e              state_q, state_d;
   logic [WCNT_W-1:0]   wait_cnt_q, wait_cnt_d;
   logic                mem_timeout_q, mem_timeout_d;
   logic [CNT_W-1:0]    stall_count_q, stall_count_d;
   logic [CNT_W-1:0]    flush_count_q, flush_count_d;

   logic [ADDR_W-1:0]   ex_rs_q, ex_rt_q, mem_dest_q, wb_dest_q;
   logic                ex_uses_rs_q, ex_uses_rt_q, mem_wr_q, wb_wr_q;

   logic                freeze_c, load_use_c, active_c;

   // Memory-wait FSM, timeout tracking and hazard decode
   always_comb begin
      state_d       = state_q;
      wait_cnt_d    = wait_cnt_q;
      mem_timeout_d = mem_timeout_q;
      freeze_c      = 1'b0;

      load_use_c = ex_mem_read && ex_reg_write && (ex_write_reg != '0) &&
                   ((id_uses_rs && (id_rs == ex_write_reg)) ||
                    (id_uses_rt && (id_rt == ex_write_reg)));

      case (state_q)
         RUN: begin
            if (mem_req && !mem_ready) begin
               freeze_c   = 1'b1;
               state_d    = MEM_WAIT;
               wait_cnt_d = '0;
            end
         end
         MEM_WAIT: begin
            if (mem_ready) begin
               state_d = RUN;
            end else begin
               freeze_c = 1'b1;
               if (wait_cnt_q != WCNT_W'(WAIT_TIMEOUT)) begin
                  wait_cnt_d = wait_cnt_q + WCNT_W'(1);
               end
               if (wait_cnt_d == WCNT_W'(WAIT_TIMEOUT)) begin
                  mem_timeout_d = 1'b1;
               end
            end
         end
         default: state_d = RUN;
      endcase

      // Freeze masks every stall/flush request; EX is held so they re-evaluate on release.
      active_c    = !rst && !freeze_c;
      freeze      = !rst && freeze_c;
      flush_if_id = active_c && ex_branch_taken;
      bubble_ex   = active_c && (ex_branch_taken || load_use_c);
      stall_if_id = active_c && load_use_c && !ex_branch_taken;

      stall_count_d = stall_count_q;
      if ((stall_if_id || freeze) && (stall_count_q != '1)) begin
         stall_count_d = stall_count_q + CNT_W'(1);
      end
      flush_count_d = flush_count_q;
      if (flush_if_id && (flush_count_q != '1)) begin
         flush_count_d = flush_count_q + CNT_W'(1);
      end
   end

   // Forwarding selects: the younger MEM producer wins over WB; R0 is never forwarded
   always_comb begin
      forward_a = FWD_REG;
      forward_b = FWD_REG;
      if (ex_uses_rs_q && (ex_rs_q != '0)) begin
         if (mem_wr_q && (mem_dest_q == ex_rs_q)) begin
            forward_a = FWD_MEM;
         end else if (wb_wr_q && (wb_dest_q == ex_rs_q)) begin
            forward_a = FWD_WB;
         end
      end
      if (ex_uses_rt_q && (ex_rt_q != '0)) begin
         if (mem_wr_q && (mem_dest_q == ex_rt_q)) begin
            forward_b = FWD_MEM;
         end else if (wb_wr_q && (wb_dest_q == ex_rt_q)) begin
            forward_b = FWD_WB;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= RUN;
         wait_cnt_q    <= '0;
         mem_timeout_q <= 1'b0;
         stall_count_q <= '0;
         flush_count_q <= '0;
      end else begin
         state_q       <= state_d;
         wait_cnt_q    <= wait_cnt_d;
         mem_timeout_q <= mem_timeout_d;
         stall_count_q <= stall_count_d;
         flush_count_q <= flush_count_d;
      end
   end

   // Shadow copies of the EX/MEM/WB register usage; all held while frozen
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ex_rs_q      <= '0;
         ex_rt_q      <= '0;
         ex_uses_rs_q <= 1'b0;
         ex_uses_rt_q <= 1'b0;
         mem_dest_q   <= '0;
         mem_wr_q     <= 1'b0;
         wb_dest_q    <= '0;
         wb_wr_q      <= 1'b0;
      end else if (!freeze_c) begin
         wb_dest_q  <= mem_dest_q;
         wb_wr_q    <= mem_wr_q;
         mem_dest_q <= ex_write_reg;
         mem_wr_q   <= ex_reg_write;
         if (bubble_ex) begin
            ex_rs_q      <= '0;
            ex_rt_q      <= '0;
            ex_uses_rs_q <= 1'b0;
            ex_uses_rt_q <= 1'b0;
         end else begin
            ex_rs_q      <= id_rs;
            ex_rt_q      <= id_rt;
            ex_uses_rs_q <= id_uses_rs;
            ex_uses_rt_q <= id_uses_rt;
         end
      end
   end

   assign mem_timeout = mem_timeout_q;
   assign stall_count = stall_count_q;
   assign flush_count = flush_count_q;

endmodule
